// File: rtl/touch_adc_pkg.sv
// Shared definitions for the touch-screen ADC SPI master: the frame FSM
// states, the Avalon register indices and the frame geometry.
package touch_adc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_CMD    = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_DATA   = 2'd2;
    localparam logic [1:0] ADDR_DIV    = 2'd3;

    // One frame is 8 command clocks followed by 16 read-back clocks.
    localparam int FRAME_CLKS    = 24;
    localparam int CAPTURE_FIRST = 9;
    // After the 16 read-back samples the busy/null bit sits at bit 15 and
    // the three trailing zeros at bits 2..0; the conversion is in between.
    localparam int RESULT_MSB    = 14;
    localparam int RESULT_LSB    = 3;

endpackage

// File: rtl/touch_adc_tick.sv
// Half-period timebase: a loadable down-counter that pulses tick for one
// cycle every div+1 clocks while enabled; load restarts the count.
module touch_adc_tick (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] div,
    output logic       tick
);

    logic [7:0] count;

    assign tick = en && !load && (count == 8'd0);

    // Reload on restart or on every expiry, otherwise count down while running.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 8'd0;
        end else if (load || tick) begin
            count <= div;
        end else if (en && (count != 8'd0)) begin
            count <= count - 8'd1;
        end
    end

endmodule

// File: rtl/touch_adc_spi_master.sv
// Autonomous SPI master for XPT2046/ADS7843-class resistive touch ADCs.
// A CMD write launches one 24-clock frame (8 command bits out, 16 bits in);
// the 12-bit conversion is then readable from DATA.
// Optional feature: define TOUCH_ADC_IRQ_EN to add the ins_irq port and the
// interrupt-enable bit (STATUS bit2).
module touch_adc_spi_master
    import touch_adc_pkg::*;
#(
    parameter logic [7:0] DIV_RESET = 8'd24
) (
    input  logic        csi_clk,
    input  logic        csi_reset,
    input  logic        avs_chipselect,
    input  logic [1:0]  avs_address,
    input  logic        avs_write_n,
    input  logic [15:0] avs_writedata,
    output logic [15:0] avs_readdata,
    output logic        coe_TCS,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
`ifdef TOUCH_ADC_IRQ_EN
    ,
    output logic        ins_irq
`endif
);

    localparam logic [4:0] LAST_BIT = 5'(FRAME_CLKS - 1);
    localparam logic [4:0] CAP_BIT  = 5'(CAPTURE_FIRST - 1);

    state_t      state;
    logic [7:0]  cmd;
    logic [7:0]  div;
    logic        busy;
    logic        done;
    logic        ie;
    logic        start;
    logic [11:0] result;
    logic [15:0] sr;
    logic [4:0]  bit_cnt;
    logic [4:0]  next_cnt;
    logic        tick;
    logic        wr_en;
    logic        rd_en;
    logic        accept;
    logic        unused_wdata;

    assign wr_en        = avs_chipselect && !avs_write_n;
    assign rd_en        = avs_chipselect && avs_write_n;
    // The cycle between the CMD write and SETUP entry counts as busy for
    // write filtering, so a second write cannot overwrite a launched command.
    assign accept       = !busy && !start;
    assign next_cnt     = bit_cnt + 5'd1;
    assign unused_wdata = ^avs_writedata[15:8];

    touch_adc_tick u_tick (
        .clk  (csi_clk),
        .rst  (csi_reset),
        .en   (busy),
        .load (start),
        .div  (div),
        .tick (tick)
    );

`ifdef TOUCH_ADC_IRQ_EN
    assign ins_irq = done && ie;
`else
    assign ie = 1'b0;
`endif

    // Register file writes and the frame FSM; done-set is written last so it
    // wins over a simultaneous done-clear.
    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            state   <= IDLE;
            cmd     <= 8'd0;
            div     <= DIV_RESET;
            busy    <= 1'b0;
            done    <= 1'b0;
            start   <= 1'b0;
            result  <= 12'd0;
            bit_cnt <= 5'd0;
            coe_TCS <= 1'b1;
            SCLK    <= 1'b0;
            MOSI    <= 1'b0;
`ifdef TOUCH_ADC_IRQ_EN
            ie      <= 1'b0;
`endif
        end else begin
            start <= 1'b0;
            if (wr_en) begin
                case (avs_address)
                    ADDR_CMD: begin
                        if (accept) begin
                            cmd   <= avs_writedata[7:0];
                            start <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                    ADDR_STATUS: begin
                        if (avs_writedata[1]) begin
                            done <= 1'b0;
                        end
`ifdef TOUCH_ADC_IRQ_EN
                        ie <= avs_writedata[2];
`endif
                    end
                    ADDR_DIV: begin
                        if (accept) begin
                            div <= avs_writedata[7:0];
                        end
                    end
                    default: ;
                endcase
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= SETUP;
                        busy    <= 1'b1;
                        coe_TCS <= 1'b0;
                        SCLK    <= 1'b0;
                        MOSI    <= cmd[7];
                        bit_cnt <= 5'd0;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!SCLK) begin
                            // Rising edge: capture the read-back half of the frame.
                            SCLK <= 1'b1;
                            if (bit_cnt >= CAP_BIT) begin
                                sr <= {sr[14:0], MISO};
                            end
                        end else begin
                            // Falling edge: start of the next low half.
                            SCLK <= 1'b0;
                            if (bit_cnt == LAST_BIT) begin
                                state <= HOLD;
                                MOSI  <= 1'b0;
                            end else begin
                                bit_cnt <= next_cnt;
                                if (next_cnt < 5'd8) begin
                                    MOSI <= cmd[3'd7 - next_cnt[2:0]];
                                end else begin
                                    MOSI <= 1'b0;
                                end
                            end
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        state   <= IDLE;
                        coe_TCS <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        result  <= sr[RESULT_MSB:RESULT_LSB];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Zero-wait-state read mux; drives zero whenever no read is in progress.
    always_comb begin
        avs_readdata = 16'd0;
        if (rd_en) begin
            case (avs_address)
                ADDR_CMD:    avs_readdata = {8'd0, cmd};
                ADDR_STATUS: avs_readdata = {13'd0, ie, done, busy};
                ADDR_DATA:   avs_readdata = {4'd0, result};
                ADDR_DIV:    avs_readdata = {8'd0, div};
                default:     avs_readdata = 16'd0;
            endcase
        end
    end

endmodule
